display_ctrl: RTL and testbench
===============================

Name: display_ctrl

Overview:
- Sequencing controller in front of the five-digit 7-segment decoder block.
- Captures an 8-bit PC value, an 8-bit x5 register value and a 4-bit status digit on request.
- Converts PC and x5 to two decimal digits each, using one shared sequential double-dabble engine: PC is converted first, then x5.
- Commits all five 4-bit digit codes to the decoder inputs atomically.

Parameters:
- LZ_BLANK, 0: when 1, a tens digit of 0 is replaced by BLANK_CODE.
- BLANK_CODE, 4'hF: digit code the decoder renders as all segments off (any value >9).

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
update  input  1  request to sample pc_val/x5_val/final_val and refresh display
pc_val  input  8  binary PC value
x5_val  input  8  binary x5 register value
final_val  input  4  status digit, passed through unconverted
pc1  output  4  PC tens digit code
pc2  output  4  PC units digit code
x5part1  output  4  x5 tens digit code
x5part2  output  4  x5 units digit code
final  output  4  status digit code
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after digits are committed

Behaviour:
- Reset:
  - FSM goes to IDLE; pending flag cleared.
  - pc1, pc2, x5part1, x5part2 and final are set to BLANK_CODE.
  - busy=0, done=0.
  - Reset mid-conversion aborts it; no partial commit occurs.
- FSM states: IDLE, CONV_PC, CONV_X5, COMMIT.
- IDLE:
  - At edge E0 with update=1, latch pc_val, x5_val and final_val into capture registers.
  - Load pc into the engine; go to CONV_PC.
- CONV_PC, edges E1..E8: 8 double-dabble iterations.
  - Each iteration: add 3 to every BCD nibble ≥5, then shift left by 1.
  - 12-bit BCD register: hundreds, tens, units.
  - At E8, the PC result is stored in a holding register, x5 is loaded into the engine, and the FSM goes to CONV_X5.
- CONV_X5, edges E9..E16: same 8 iterations on x5. At E16 go to COMMIT.
- COMMIT, edge E17: all five outputs update in the same edge; done=1 during the cycle after E17.
  - Next state is CONV_PC if pending=1 (new capture occurs at E17, pending cleared); otherwise IDLE.
- Latency: update sampled at E0 → outputs valid after E17 (17 clocks). Throughput: one refresh per 17 clocks.
- Digit mapping per value:
  - Hundreds ≠ 0 (value >99): both digits = BLANK_CODE (overflow blank).
  - Otherwise tens → first digit, units → second digit.
  - LZ_BLANK=1 and tens=0: first digit = BLANK_CODE. Units is never blanked, so 0 shows as a single "0".
- final output = captured final_val, unmodified.
- update while busy:
  - Sets pending; not lost, not queued deeper. Multiple requests collapse to one.
  - The re-run samples inputs at E17, not at request time.
- update in the same cycle as COMMIT: treated as pending → immediate re-run.
- Outputs hold their last committed values between commits. Inputs are not observed except at capture edges.

Decomposition:
- Shared package display_pkg:
  - FSM state enum.
  - BLANK_CODE default.
  - BCD_DIGITS=3.
  - BIN_W=8.
  - Iteration count = BIN_W.
- One natural sub-module, bin2bcd_seq:
  - Ports: load/start, 8-bit bin in, 12-bit bcd out, 4-bit iteration counter, done flag.
  - Instantiated once and time-shared between PC and x5 by the FSM.

Test Plan:
1. Reset, then update with pc_val=42, x5_val=7, final_val=1, LZ_BLANK=0 → after 17 clocks: pc1=4, pc2=2, x5part1=0, x5part2=7, final=1; done pulses exactly once; busy high for 17 cycles.
2. Boundaries, pc_val=99/100/0 and x5_val=255 → PC shows 9,9 / F,F / 0,0; x5 shows F,F.
3. LZ_BLANK=1, x5_val=7, pc_val=0 → x5part1=F, x5part2=7, pc1=F, pc2=0.
4. Updates at E0 (pc=12) and E5 (pc=34), plus a second update at E6 → two done pulses only; first commit shows 1,2; second commit, 17 clocks later, shows 3,4; inputs changed mid-conversion do not affect the first result.
5. rst asserted at E10 of a conversion → next cycle: all outputs = F, busy=0, no done pulse; a later update converts normally.
6. update held high continuously → back-to-back refreshes every 17 clocks, each done pulse one cycle wide, outputs never show mixed old/new digits.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the display sequencing controller and its BCD engine.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONV_PC = 2'd1,
        CONV_X5 = 2'd2,
        COMMIT  = 2'd3
    } state_t;

    localparam logic [3:0] BLANK_CODE_DEF = 4'hF;
    localparam int         BCD_DIGITS     = 3;
    localparam int         BIN_W          = 8;
    localparam int         BCD_W          = 4 * BCD_DIGITS;
    localparam int         ITERS          = BIN_W;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift iteration per clock.
// bcd presents the value produced by the iteration completing at the next
// edge, so the caller can capture the final result on the same edge that
// finishes it; done flags that final iteration.
module bin2bcd_seq
    import display_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [BIN_W-1:0] bin,
    output logic [BCD_W-1:0] bcd,
    output logic [3:0]       iter,
    output logic             done
);

    logic [3:0]       cnt;
    logic             active;
    logic [BCD_W-1:0] bcd_q;
    logic [BCD_W-1:0] adj;
    logic [BCD_W-1:0] bcd_nxt;
    logic [BIN_W-1:0] bin_q;
    logic [BIN_W-1:0] bin_nxt;

    assign active = (cnt != 4'(ITERS));
    assign bcd    = bcd_nxt;
    assign iter   = cnt;
    assign done   = (cnt == 4'(ITERS - 1));

    // One double-dabble step: correct every nibble >= 5, then shift left.
    always_comb begin
        adj = bcd_q;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (adj[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
            end
        end
        {bcd_nxt, bin_nxt} = {adj, bin_q} << 1;
    end

    // Iteration counter; parks at ITERS when no conversion is running.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 4'(ITERS);
        end else if (load) begin
            cnt <= 4'd0;
        end else if (active) begin
            cnt <= cnt + 4'd1;
        end
    end

    // Shift register datapath: a load restarts from zero BCD.
    always_ff @(posedge clk) begin
        if (load) begin
            bcd_q <= '0;
            bin_q <= bin;
        end else if (active) begin
            bcd_q <= bcd_nxt;
            bin_q <= bin_nxt;
        end
    end

endmodule

// File: rtl/display_ctrl.sv
// Sequencing controller for the five-digit 7-segment decoder: captures PC,
// x5 and a status digit, converts PC then x5 on one shared BCD engine, and
// commits all five digit codes on a single edge. The status digit output is
// named final_digit because "final" is a reserved word.
module display_ctrl
    import display_pkg::*;
#(
    parameter bit         LZ_BLANK   = 1'b0,
    parameter logic [3:0] BLANK_CODE = BLANK_CODE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             update,
    input  logic [BIN_W-1:0] pc_val,
    input  logic [BIN_W-1:0] x5_val,
    input  logic [3:0]       final_val,
    output logic [3:0]       pc1,
    output logic [3:0]       pc2,
    output logic [3:0]       x5part1,
    output logic [3:0]       x5part2,
    output logic [3:0]       final_digit,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic             pending;
    logic             cap_en;
    logic             eng_load;
    logic             eng_done;
    logic [BIN_W-1:0] eng_bin;
    logic [BCD_W-1:0] eng_bcd;
    logic [3:0]       eng_iter_unused;
    logic [BIN_W-1:0] cap_x5_p0;
    logic [3:0]       cap_final_p0;
    logic [BCD_W-1:0] hold_pc_p1;
    logic [BCD_W-1:0] hold_x5_p1;
    logic [7:0]       pc_digits;
    logic [7:0]       x5_digits;

    // Turns a 3-digit BCD value into {first, second} display codes.
    function automatic logic [7:0] map_digits(input logic [BCD_W-1:0] v);
        logic [3:0] first;
        if (v[BCD_W-1 -: 4] != 4'd0) begin
            return {BLANK_CODE, BLANK_CODE};
        end
        first = v[7:4];
        if (LZ_BLANK && (v[7:4] == 4'd0)) begin
            first = BLANK_CODE;
        end
        return {first, v[3:0]};
    endfunction

    bin2bcd_seq u_bcd (
        .clk  (clk),
        .rst  (rst),
        .load (eng_load),
        .bin  (eng_bin),
        .bcd  (eng_bcd),
        .iter (eng_iter_unused),
        .done (eng_done)
    );

    assign pc_digits = map_digits(hold_pc_p1);
    assign x5_digits = map_digits(hold_x5_p1);

    // Decide when to capture inputs and what the engine is loaded with.
    always_comb begin
        cap_en   = 1'b0;
        eng_load = 1'b0;
        eng_bin  = pc_val;
        case (state)
            IDLE:    cap_en = update;
            CONV_PC: begin
                eng_load = eng_done;
                eng_bin  = cap_x5_p0;
            end
            COMMIT:  cap_en = pending | update;
            default: ;
        endcase
        if (cap_en) begin
            eng_load = 1'b1;
        end
    end

    // Capture and holding registers for values in flight.
    always_ff @(posedge clk) begin
        if (cap_en) begin
            cap_x5_p0    <= x5_val;
            cap_final_p0 <= final_val;
        end
        if ((state == CONV_PC) && eng_done) begin
            hold_pc_p1 <= eng_bcd;
        end
        if ((state == CONV_X5) && eng_done) begin
            hold_x5_p1 <= eng_bcd;
        end
    end

    // Controller FSM with registered busy/done and atomic digit commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pending     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pc1         <= BLANK_CODE;
            pc2         <= BLANK_CODE;
            x5part1     <= BLANK_CODE;
            x5part2     <= BLANK_CODE;
            final_digit <= BLANK_CODE;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (update) begin
                        state <= CONV_PC;
                        busy  <= 1'b1;
                    end
                end
                CONV_PC: begin
                    if (update) pending <= 1'b1;
                    if (eng_done) state <= CONV_X5;
                end
                CONV_X5: begin
                    if (update) pending <= 1'b1;
                    if (eng_done) state <= COMMIT;
                end
                COMMIT: begin
                    pc1         <= pc_digits[7:4];
                    pc2         <= pc_digits[3:0];
                    x5part1     <= x5_digits[7:4];
                    x5part2     <= x5_digits[3:0];
                    final_digit <= cap_final_p0;
                    done        <= 1'b1;
                    pending     <= 1'b0;
                    if (pending || update) begin
                        state <= CONV_PC;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_display_ctrl.sv
// Scoreboard bench for display_ctrl: two instances (leading-zero blanking
// off and on) share one stimulus stream; a request-level model predicts
// commits, a monitor pops and compares them whenever done is seen.
module tb_display_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       update;
    logic [7:0] pc_val;
    logic [7:0] x5_val;
    logic [3:0] final_val;

    logic [3:0] a_pc1, a_pc2, a_x1, a_x2, a_fin;
    logic       a_busy, a_done;
    logic [3:0] b_pc1, b_pc2, b_x1, b_x2, b_fin;
    logic       b_busy, b_done;

    typedef struct {
        int pc1;
        int pc2;
        int x1;
        int x2;
        int fin;
    } disp_t;

    disp_t q0[$];
    disp_t q1[$];
    disp_t d0, d1;

    int total = 0;
    int bad   = 0;

    // model state: cycles left until commit, collapsed pending request
    int rem  = 0;
    bit pend = 1'b0;
    bit edone = 1'b0;
    int cpc, cx5, cfin;

    always #5 clk = ~clk;

    display_ctrl #(.LZ_BLANK(1'b0), .BLANK_CODE(4'hF)) dut0 (
        .clk(clk), .rst(rst), .update(update), .pc_val(pc_val), .x5_val(x5_val),
        .final_val(final_val), .pc1(a_pc1), .pc2(a_pc2), .x5part1(a_x1),
        .x5part2(a_x2), .final_digit(a_fin), .busy(a_busy), .done(a_done)
    );

    display_ctrl #(.LZ_BLANK(1'b1), .BLANK_CODE(4'hF)) dut1 (
        .clk(clk), .rst(rst), .update(update), .pc_val(pc_val), .x5_val(x5_val),
        .final_val(final_val), .pc1(b_pc1), .pc2(b_pc2), .x5part1(b_x1),
        .x5part2(b_x2), .final_digit(b_fin), .busy(b_busy), .done(b_done)
    );

    function automatic int tens_code(int v, bit lz);
        if (v > 99) return 15;
        if (lz && (v / 10 == 0)) return 15;
        return v / 10;
    endfunction

    function automatic int units_code(int v);
        if (v > 99) return 15;
        return v % 10;
    endfunction

    function automatic disp_t make_disp(int pc, int x5, int fin, bit lz);
        disp_t d;
        d.pc1 = tens_code(pc, lz);
        d.pc2 = units_code(pc);
        d.x1  = tens_code(x5, lz);
        d.x2  = units_code(x5);
        d.fin = fin;
        return d;
    endfunction

    function automatic disp_t blank_disp();
        disp_t d;
        d.pc1 = 15; d.pc2 = 15; d.x1 = 15; d.x2 = 15; d.fin = 15;
        return d;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_disp(input string tag, input int p1, input int p2,
                            input int x1, input int x2, input int f, input disp_t e);
        check({tag, ".pc1"}, p1, e.pc1);
        check({tag, ".pc2"}, p2, e.pc2);
        check({tag, ".x5part1"}, x1, e.x1);
        check({tag, ".x5part2"}, x2, e.x2);
        check({tag, ".final"}, f, e.fin);
    endtask

    // One clock: drive inputs, advance the model at the edge, check control/display.
    task automatic step(input bit r, input bit u, input int pc, input int x5, input int fin);
        rst       = r;
        update    = u;
        pc_val    = 8'(pc);
        x5_val    = 8'(x5);
        final_val = 4'(fin);
        @(posedge clk);
        edone = 1'b0;
        if (r) begin
            rem  = 0;
            pend = 1'b0;
            d0   = blank_disp();
            d1   = blank_disp();
        end else if (rem == 0) begin
            if (u) begin
                cpc = pc; cx5 = x5; cfin = fin;
                rem = 17;
            end
        end else begin
            rem--;
            if (rem == 0) begin
                d0 = make_disp(cpc, cx5, cfin, 1'b0);
                d1 = make_disp(cpc, cx5, cfin, 1'b1);
                q0.push_back(d0);
                q1.push_back(d1);
                edone = 1'b1;
                if (pend || u) begin
                    cpc = pc; cx5 = x5; cfin = fin;
                    rem  = 17;
                    pend = 1'b0;
                end
            end else if (u) begin
                pend = 1'b1;
            end
        end
        #1;
        check("dut0.busy", int'(a_busy), int'(rem > 0));
        check("dut1.busy", int'(b_busy), int'(rem > 0));
        check("dut0.done", int'(a_done), int'(edone));
        check("dut1.done", int'(b_done), int'(edone));
        cmp_disp("dut0.hold", a_pc1, a_pc2, a_x1, a_x2, a_fin, d0);
        cmp_disp("dut1.hold", b_pc1, b_pc2, b_x1, b_x2, b_fin, d1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0);
    endtask

    // Monitor: every done pulse must match the next queued commit.
    initial begin
        disp_t e;
        forever begin
            @(negedge clk);
            if (a_done === 1'b1) begin
                if (q0.size() == 0) begin
                    check("dut0.unexpected_done", 1, 0);
                end else begin
                    e = q0.pop_front();
                    cmp_disp("dut0.commit", a_pc1, a_pc2, a_x1, a_x2, a_fin, e);
                end
            end
            if (b_done === 1'b1) begin
                if (q1.size() == 0) begin
                    check("dut1.unexpected_done", 1, 0);
                end else begin
                    e = q1.pop_front();
                    cmp_disp("dut1.commit", b_pc1, b_pc2, b_x1, b_x2, b_fin, e);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int bnd[6];
        int pc, x5;
        bit r, u;
        bnd[0] = 0; bnd[1] = 9; bnd[2] = 10; bnd[3] = 99; bnd[4] = 100; bnd[5] = 255;
        d0 = blank_disp();
        d1 = blank_disp();
        rst = 1'b1; update = 1'b0; pc_val = '0; x5_val = '0; final_val = '0;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 0, 0);
        idle(2);

        // basic conversion
        step(1'b0, 1'b1, 42, 7, 1);
        idle(20);

        // decimal boundaries
        step(1'b0, 1'b1, 99, 255, 2);  idle(18);
        step(1'b0, 1'b1, 100, 255, 3); idle(18);
        step(1'b0, 1'b1, 0, 255, 4);   idle(18);
        step(1'b0, 1'b1, 0, 7, 5);     idle(18);

        // request while busy, inputs changing mid-conversion
        step(1'b0, 1'b1, 12, 56, 6);
        for (int i = 1; i < 5; i++) step(1'b0, 1'b0, 34, 78, 7);
        step(1'b0, 1'b1, 34, 78, 7);
        step(1'b0, 1'b1, 34, 78, 7);
        for (int i = 0; i < 35; i++) step(1'b0, 1'b0, 34, 78, 7);

        // reset in the middle of a conversion
        step(1'b0, 1'b1, 61, 23, 8);
        for (int i = 1; i < 10; i++) step(1'b0, 1'b0, 61, 23, 8);
        step(1'b1, 1'b0, 61, 23, 8);
        idle(3);
        step(1'b0, 1'b1, 58, 3, 9);
        idle(18);

        // update held high: back-to-back refreshes
        for (int i = 0; i < 60; i++) begin
            step(1'b0, 1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 15)));
        end
        idle(20);

        // random traffic with occasional resets
        for (int i = 0; i < 500; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            u  = ($urandom_range(0, 5) == 0);
            pc = ($urandom_range(0, 2) == 0) ? bnd[$urandom_range(0, 5)] : int'($urandom_range(0, 255));
            x5 = ($urandom_range(0, 2) == 0) ? bnd[$urandom_range(0, 5)] : int'($urandom_range(0, 255));
            step(r, u, pc, x5, int'($urandom_range(0, 15)));
        end
        idle(40);

        check("dut0.pending_commits", q0.size(), 0);
        check("dut1.pending_commits", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
